// File: rtl/wb_regfile.sv
// wb_regfile: writeback result select, 31x XLEN register file (x0 hardwired 0), two async read ports
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   RegWriteW, RdW                  commit enable and destination index for the W-stage instruction
//   ResultSrcW                      00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 lAuiPCW
//   ALUResultW, ReadDataW,
//   PCPlus4W, lAuiPCW               candidate writeback results
//   A1D, A2D / RD1D, RD2D           decode-stage read indices and combinational read data
//   ResultW                         selected result, also feeds E-stage forwarding
//   WriteEnW                        effective write strobe
// Define REGFILE_BYPASS_EN for same-cycle write-through on both read ports.
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [XLEN-1:0] lAuiPCW,
    input  logic [4:0]      RdW,
    input  logic [4:0]      A1D,
    input  logic [4:0]      A2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic            WriteEnW
);
    logic [XLEN-1:0] rf [1:NREG-1];
    assign ResultW = ResultSrcW[1] ? (ResultSrcW[0] ? lAuiPCW : PCPlus4W)
                                   : (ResultSrcW[0] ? ReadDataW : ALUResultW);
    assign WriteEnW = RegWriteW && (RdW != '0) && rst_n;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) rf[i] <= '0;
        end else if (WriteEnW) begin
            rf[RdW] <= ResultW;
        end
    end
`ifdef REGFILE_BYPASS_EN
    // WriteEnW already excludes x0 and reset, so the bypass can never make x0 nonzero
    assign RD1D = (A1D == '0) ? '0 : (WriteEnW && A1D == RdW) ? ResultW : rf[A1D];
    assign RD2D = (A2D == '0) ? '0 : (WriteEnW && A2D == RdW) ? ResultW : rf[A2D];
`else
    assign RD1D = (A1D == '0) ? '0 : rf[A1D];
    assign RD2D = (A2D == '0) ? '0 : rf[A2D];
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed + random checks of wb_regfile against an array-based architectural model
module tb_wb_regfile;
    logic        clk = 0, rst_n = 0, rw = 0;
    logic [1:0]  sel = 0;
    logic [31:0] alu = 0, rdd = 0, pc4 = 0, aui = 0;
    logic [4:0]  rd = 0, a1 = 0, a2 = 0;
    logic [31:0] rd1, rd2, res;
    logic        we;
    logic [31:0] m [32];
    int errors = 0, checks = 0;

    wb_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(rw), .ResultSrcW(sel),
        .ALUResultW(alu), .ReadDataW(rdd), .PCPlus4W(pc4), .lAuiPCW(aui),
        .RdW(rd), .A1D(a1), .A2D(a2), .RD1D(rd1), .RD2D(rd2),
        .ResultW(res), .WriteEnW(we)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] res_m();
        logic [31:0] s [4];
        s = '{alu, rdd, pc4, aui};
        return s[sel];
    endfunction

    function automatic logic we_m();
        return rw && rd != 0 && rst_n;
    endfunction

    function automatic logic [31:0] rd_m(logic [4:0] a);
        if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (we_m() && a == rd) return res_m();
`endif
        return m[a];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_now(string tag);
        #1;
        chk({tag, "_res"}, res, res_m());
        chk({tag, "_we"}, {31'b0, we}, {31'b0, we_m()});
        chk({tag, "_rd1"}, rd1, rd_m(a1));
        chk({tag, "_rd2"}, rd2, rd_m(a2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) for (int i = 0; i < 32; i++) m[i] = 0;
        else if (we_m()) m[rd] = res_m();
        #1;
    endtask

    task automatic sweep(string tag);
        rw = 0;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            chk({tag, "_rd1"}, rd1, rd_m(a1));
            chk({tag, "_rd2"}, rd2, rd_m(a2));
        end
    endtask

    task automatic wr(logic [4:0] r, logic [31:0] v);
        rw = 1; rd = r; alu = v; sel = 0;
        check_now("wr");
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 0;
        // reset held for two edges with a write pending
        rw = 1; rd = 5; alu = 32'hDEADBEEF;
        check_now("rst");
        chk("rst_we0", {31'b0, we}, 32'h0);
        tick();
        tick();
        rst_n = 1;
        sweep("rst_sweep");
        a1 = 5; #1;
        chk("rst_x5", rd1, 32'h0);
        // result mux sweep into x7
        alu = 32'h11; rdd = 32'h22; pc4 = 32'h33; aui = 32'h44;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); rw = 1; rd = 7; a2 = 7;
            check_now("mux");
            chk("mux_res", res, 32'h11 * (s + 1));
            tick();
            chk("mux_rb", rd2, 32'h11 * (s + 1));
        end
        // x0 immunity
        rw = 1; rd = 0; alu = 32'hFFFFFFFF; sel = 0; a1 = 0;
        check_now("x0");
        chk("x0_we", {31'b0, we}, 32'h0);
        chk("x0_same", rd1, 32'h0);
        tick();
        chk("x0_next", rd1, 32'h0);
        sweep("x0_sweep");
        // read-during-write
        wr(9, 32'hAAAA0000);
        rw = 1; rd = 9; alu = 32'h1234; sel = 0; a1 = 9; a2 = 9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_rd1", rd1, 32'h1234);
        chk("rdw_rd2", rd2, 32'h1234);
`else
        chk("rdw_rd1", rd1, 32'hAAAA0000);
        chk("rdw_rd2", rd2, 32'hAAAA0000);
`endif
        tick();
        rw = 0; #1;
        chk("rdw_next1", rd1, 32'h1234);
        chk("rdw_next2", rd2, 32'h1234);
        // write disabled
        wr(3, 32'h99);
        rw = 0; rd = 3; alu = 32'h55; a1 = 3;
        tick();
        chk("wdis_x3", rd1, 32'h99);
        // back-to-back with reset on the third edge
        wr(1, 1);
        wr(2, 2);
        rw = 1; rd = 3; alu = 3; rst_n = 0;
        check_now("b2b_rst");
        tick();
        rst_n = 1; rw = 0; a1 = 1; a2 = 2; #1;
        chk("b2b_x1", rd1, 32'h0);
        chk("b2b_x2", rd2, 32'h0);
        a1 = 3; #1;
        chk("b2b_x3", rd1, 32'h0);
        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            rw = 1'($urandom);
            sel = 2'($urandom);
            alu = $urandom; rdd = $urandom; pc4 = $urandom; aui = $urandom;
            rd = 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            check_now("rnd");
            tick();
        end
        rst_n = 1;
        sweep("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
